popcount_iter_nbit: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 64-bit popcount.
- Counts the set bits of a WIDTH-bit word at CHUNK bits per cycle, trading latency for area.
- Optionally accumulates counts across a multi-word burst delimited by in_last.
- Sits between a valid/ready word source and a count consumer in the benchmark datapath.

---
 rtl/popcount_iter_nbit_if.sv | 26 ++
 rtl/popcount_iter_nbit.sv | 107 ++++++++++
 tb/tb_popcount_iter_nbit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/popcount_iter_nbit_if.sv
// Word-in / count-out handshake bundle for the iterative popcount block.
// The slave modport is the counter; master is the word source plus count consumer.
interface popcount_iter_nbit_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             acc_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, acc_mode, out_ready,
        input  in_ready, out_valid, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, acc_mode, out_ready,
        output in_ready, out_valid, out_count, out_ovf
    );
endinterface

// File: rtl/popcount_iter_nbit.sv
// Multi-cycle popcount: counts CHUNK bits per cycle of a WIDTH-bit word, with
// optional saturating accumulation across a burst closed by in_last.
module popcount_iter_nbit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    popcount_iter_nbit_if.slave bus
);
    localparam int N      = WIDTH / CHUNK;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic             last_reg, last_next;
    logic             mode_reg, mode_next;
    logic [CNT_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;

    logic [PC_W-1:0]  chunk_cnt;
    logic [CNT_W:0]   sum;
    logic             sat;
    logic             last_beat;

    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + PC_W'(shift_reg[i]);
        end
    end

    // One extra bit catches the carry that means the accumulator would overflow.
    assign sum       = {1'b0, acc_reg} + (CNT_W + 1)'(chunk_cnt);
    assign sat       = sum[CNT_W];
    assign last_beat = (beat_reg == BEAT_W'(N - 1));

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign bus.in_ready  = rst_n & (state_reg == IDLE);
    assign bus.out_valid = rst_n & (state_reg == DONE);
    assign bus.out_count = rst_n ? acc_reg : '0;
    assign bus.out_ovf   = rst_n & ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            beat_reg  <= '0;
            last_reg  <= 1'b0;
            mode_reg  <= 1'b0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            beat_reg  <= beat_next;
            last_reg  <= last_next;
            mode_reg  <= mode_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        beat_next  = beat_reg;
        last_next  = last_reg;
        mode_next  = mode_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    shift_next = bus.in_data;
                    last_next  = bus.in_last;
                    mode_next  = bus.acc_mode;
                    beat_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next   = sat ? '1 : sum[CNT_W-1:0];
                ovf_next   = ovf_reg | sat;
                shift_next = shift_reg >> CHUNK;
                beat_next  = beat_reg + BEAT_W'(1);
                // A mid-burst accumulating word keeps its total and emits nothing.
                if (last_beat) begin
                    state_next = (mode_reg && !last_reg) ? IDLE : DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_popcount_iter_nbit.sv
// Self-checking bench: two counters (16-bit and 7-bit results) share one stimulus
// stream; each is compared against a burst-total model built on $countones.
module tb_popcount_iter_nbit;
    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             acc_mode = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;

    popcount_iter_nbit_if #(.WIDTH(WIDTH), .CNT_W(16)) bus16 ();
    popcount_iter_nbit_if #(.WIDTH(WIDTH), .CNT_W(7))  bus7 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.in_last   = in_last;
    assign bus16.acc_mode  = acc_mode;
    assign bus16.out_ready = out_ready;
    assign bus7.in_valid   = in_valid;
    assign bus7.in_data    = in_data;
    assign bus7.in_last    = in_last;
    assign bus7.acc_mode   = acc_mode;
    assign bus7.out_ready  = out_ready;

    popcount_iter_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
    );
    popcount_iter_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(7)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus7.slave)
    );

    int errors = 0;
    int checks = 0;
    longint total = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        mode;
        int          hold;
        logic        exp_valid;
        logic [15:0] exp_count;
    } vec_t;
    vec_t vecs [0:6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat_model(input longint t, input int cw);
        longint max_v;
        max_v = (longint'(1) << cw) - 1;
        return (t > max_v) ? max_v : t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one word, follows it through RUN, checks the result against the model
    // and completes the output handshake after 'hold' cycles of backpressure.
    task automatic run_word(input logic [63:0] data, input logic last, input logic mode,
                            input int hold, output logic got_valid, output logic [15:0] got_count);
        int          waited;
        logic        exp_res;
        logic [15:0] held;
        waited = 0;
        while (!bus16.in_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("ready_before_accept", bus16.in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        acc_mode = mode;
        step();
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
        acc_mode = 1'($urandom_range(0, 1));
        total   += $countones(data);
        exp_res  = !(mode && !last);
        chk("run_in_ready", bus16.in_ready, 0);
        for (int i = 1; i < N; i++) begin
            chk("run_out_valid", bus16.out_valid, 0);
            step();
        end
        chk("last_beat_in_ready", bus16.in_ready, 0);
        step();
        in_valid  = 1'b0;
        got_valid = bus16.out_valid;
        got_count = bus16.out_count;
        chk("result_valid16", bus16.out_valid, exp_res);
        chk("result_valid7", bus7.out_valid, exp_res);
        if (exp_res) begin
            chk("count16", bus16.out_count, sat_model(total, 16));
            chk("ovf16", bus16.out_ovf, (total > 65535) ? 1 : 0);
            chk("count7", bus7.out_count, sat_model(total, 7));
            chk("ovf7", bus7.out_ovf, (total > 127) ? 1 : 0);
            held = bus16.out_count;
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom};
                step();
                chk("hold_valid", bus16.out_valid, 1);
                chk("hold_count", bus16.out_count, held);
                chk("hold_in_ready", bus16.in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("post_hs_valid", bus16.out_valid, 0);
            chk("post_hs_ready16", bus16.in_ready, 1);
            chk("post_hs_ready7", bus7.in_ready, 1);
            total = 0;
        end else begin
            chk("no_result_ready", bus16.in_ready, 1);
        end
        $display("word data=%h last=%0d mode=%0d -> valid=%0d count16=%0d model_total_pending=%0d",
                 data, last, mode, got_valid, got_count, total);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gv;
        logic [15:0] gc;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0,  1'b1, 16'd64};
        vecs[1] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 0,  1'b1, 16'd0};
        vecs[2] = '{64'h8000_0000_0000_0001, 1'b0, 1'b0, 0,  1'b1, 16'd2};
        vecs[3] = '{64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 10, 1'b1, 16'd32};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0,  1'b0, 16'd0};
        vecs[5] = '{64'h5555_5555_5555_5555, 1'b0, 1'b1, 0,  1'b0, 16'd0};
        vecs[6] = '{64'h0000_0000_0000_0001, 1'b1, 1'b1, 2,  1'b1, 16'd97};

        repeat (3) step();
        chk("rst_in_ready", bus16.in_ready, 0);
        chk("rst_out_valid", bus16.out_valid, 0);
        chk("rst_out_count", bus16.out_count, 0);
        chk("rst_out_ovf", bus16.out_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus16.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_word(vecs[i].data, vecs[i].last, vecs[i].mode, vecs[i].hold, gv, gc);
            chk("vec_valid", gv, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk("vec_count", gc, vecs[i].exp_count);
        end

        // Saturating burst on the 7-bit instance, then a clean per-word result.
        run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, gv, gc);
        run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, gv, gc);
        run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1, gv, gc);
        chk("burst192_count16", gc, 192);
        run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, gv, gc);
        chk("after_sat_count16", gc, 64);

        for (int r = 0; r < 40; r++) begin
            logic [63:0] d;
            case ($urandom_range(0, 3))
                0:       d = '1;
                1:       d = '0;
                default: d = {$urandom, $urandom};
            endcase
            run_word(d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), gv, gc);
        end

        // Reset during beat 4 of an all-ones word discards everything in flight.
        in_valid = 1'b1;
        in_data  = '1;
        in_last  = 1'b0;
        acc_mode = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", bus16.out_valid, 0);
        chk("midrst_out_count", bus16.out_count, 0);
        chk("midrst_in_ready", bus16.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_ready", bus16.in_ready, 1);
        chk("midrst_release_count", bus16.out_count, 0);
        total = 0;
        run_word(64'h0000_0000_0000_00FF, 1'b0, 1'b0, 0, gv, gc);
        chk("fresh_word_count", gc, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
